sprite_anim_rom: RTL and testbench

Parametrised, animated sprite ROM for the VGA pixel path. It takes the current scan pixel and a sprite position, then checks whether the pixel falls inside the sprite box. It reads a multi-frame block ROM and returns a 12-bit colour plus an opaque flag that the mixer uses to overlay the sprite on the background. It adds horizontal mirroring, a transparent colour key and frame-based animation.

---
 rtl/sprite_anim_rom.sv | 110 +++++++++++
 tb/tb_sprite_anim_rom.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_rom.sv
// Animated sprite ROM for the VGA pixel path: box test, mirrored addressing,
// frame-major multi-frame ROM and a colour-keyed opaque flag, 2-clock latency.
module sprite_anim_rom #(
  parameter int                 SPR_W       = 10,
  parameter int                 SPR_H       = 20,
  parameter int                 NUM_FRAMES  = 4,
  parameter int                 FRAME_TICKS = 8,
  parameter int                 COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
  parameter int                 X_W         = 10,
  parameter int                 Y_W         = 10,
  parameter string              MEM_FILE    = "sprite.mem",
  localparam int                FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [X_W-1:0]     pix_x,
  input  logic [Y_W-1:0]     pix_y,
  input  logic [X_W-1:0]     sprite_x,
  input  logic [Y_W-1:0]     sprite_y,
  input  logic               mirror,
  input  logic               anim_en,
  input  logic               frame_tick,
  output logic [COLOR_W-1:0] color_data,
  output logic               sprite_on,
  output logic [FRAME_W-1:0] anim_frame
);

  localparam int FRAME_SIZE = SPR_W * SPR_H;
  localparam int ROM_DEPTH  = FRAME_SIZE * NUM_FRAMES;
  localparam int ADDR_W     = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  logic [X_W-1:0]     x_act;
  logic [Y_W-1:0]     y_act;
  logic               mirror_act;
  logic [TICK_W-1:0]  tick_cnt;

  logic               in_box;
  logic [X_W-1:0]     dx;
  logic [Y_W-1:0]     dy;
  logic [X_W-1:0]     col;
  logic [ADDR_W-1:0]  addr_calc;
  logic [X_W:0]       x_end;
  logic [Y_W:0]       y_end;

  logic [ADDR_W-1:0]  addr_q1;
  logic               in_box_q1;
  logic               in_box_q2;
  logic [COLOR_W-1:0] rom_q;

  (* rom_style = "block" *) logic [COLOR_W-1:0] rom [0:ROM_DEPTH-1];

  // Position and mirror only change at frame boundaries, so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_act      <= '0;
      y_act      <= '0;
      mirror_act <= 1'b0;
      tick_cnt   <= '0;
      anim_frame <= '0;
    end else if (frame_tick) begin
      x_act      <= sprite_x;
      y_act      <= sprite_y;
      mirror_act <= mirror;
      if (anim_en) begin
        if (tick_cnt == TICK_W'(FRAME_TICKS - 1)) begin
          tick_cnt   <= '0;
          anim_frame <= (anim_frame == FRAME_W'(NUM_FRAMES - 1)) ? '0
                                                                 : anim_frame + FRAME_W'(1);
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end
    end
  end

  // Box edges are one bit wider than the position so a sprite near the
  // right/bottom border clips instead of wrapping.
  always_comb begin
    x_end  = {1'b0, x_act} + (X_W+1)'(SPR_W);
    y_end  = {1'b0, y_act} + (Y_W+1)'(SPR_H);
    in_box = ({1'b0, pix_x} >= {1'b0, x_act}) && ({1'b0, pix_x} < x_end) &&
             ({1'b0, pix_y} >= {1'b0, y_act}) && ({1'b0, pix_y} < y_end);
    dx     = pix_x - x_act;
    dy     = pix_y - y_act;
    col    = mirror_act ? (X_W'(SPR_W - 1) - dx) : dx;
    addr_calc = ADDR_W'(int'(anim_frame) * FRAME_SIZE + int'(dy) * SPR_W + int'(col));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q1   <= '0;
      in_box_q1 <= 1'b0;
      in_box_q2 <= 1'b0;
    end else begin
      addr_q1   <= in_box ? addr_calc : '0;
      in_box_q1 <= in_box;
      in_box_q2 <= in_box_q1;
    end
  end

  always_ff @(posedge clk) begin
    rom_q <= rom[addr_q1];
  end

  assign sprite_on  = in_box_q2 && (rom_q != TRANSPARENT);
  assign color_data = sprite_on ? rom_q : '0;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// Bench for sprite_anim_rom: ROM holds mem[a]=a, expected pixels are queued on
// drive and compared two clocks later.
module tb_sprite_anim_rom;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y, sprite_x, sprite_y;
  logic        mirror, anim_en, frame_tick;
  logic [11:0] color_data;
  logic        sprite_on;
  logic [1:0]  anim_frame;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [11:0] col;
    logic        on;
    string       nm;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  sprite_anim_rom #(.MEM_FILE("")) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .mirror     (mirror),
    .anim_en    (anim_en),
    .frame_tick (frame_tick),
    .color_data (color_data),
    .sprite_on  (sprite_on),
    .anim_frame (anim_frame)
  );

  // One pixel per clock; the entry pushed two steps earlier is due after this edge.
  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic chk,
                      input logic [11:0] ec, input logic eo, input string nm);
    exp_t e;
    pix_x = x;
    pix_y = y;
    exp_q.push_back('{chk, ec, eo, nm});
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (color_data !== e.col || sprite_on !== e.on) begin
          errors++;
          $display("FAIL %s: color_data=%0d sprite_on=%0b expected color_data=%0d sprite_on=%0b",
                   e.nm, color_data, sprite_on, e.col, e.on);
        end
      end
    end
  endtask

  task automatic filler(input int n);
    repeat (n) step(10'd1023, 10'd1023, 1'b1, 12'd0, 1'b0, "idle");
  endtask

  task automatic tick_frames(input int n);
    frame_tick = 1'b1;
    repeat (n) step(10'd1023, 10'd1023, 1'b1, 12'd0, 1'b0, "tick_idle");
    frame_tick = 1'b0;
  endtask

  task automatic check_frame(input logic [1:0] exp, input string nm);
    checks++;
    if (anim_frame !== exp) begin
      errors++;
      $display("FAIL %s: anim_frame=%0d expected %0d", nm, anim_frame, exp);
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    checks++;
    if (color_data !== 12'd0 || sprite_on !== 1'b0) begin
      errors++;
      $display("FAIL %s: color_data=%0d sprite_on=%0b expected 0/0", nm, color_data, sprite_on);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(10'd1023, 10'd1023, 1'b0, 12'd0, 1'b0, "rst");
    step(10'd1023, 10'd1023, 1'b0, 12'd0, 1'b0, "rst");
    check_outputs_zero("reset_outputs");
    check_frame(2'd0, "reset_frame");
    reset = 1'b0;
    filler(2);
  endtask

  task automatic test_basic();
    sprite_x = 10'd100;
    sprite_y = 10'd50;
    tick_frames(1);
    step(10'd103, 10'd52, 1'b1, 12'd23, 1'b1, "basic");
    filler(1);
  endtask

  task automatic test_box_edges();
    step(10'd110, 10'd52, 1'b1, 12'd0,   1'b0, "right_out");
    step(10'd99,  10'd52, 1'b1, 12'd0,   1'b0, "left_out");
    step(10'd100, 10'd70, 1'b1, 12'd0,   1'b0, "bottom_out");
    step(10'd100, 10'd49, 1'b1, 12'd0,   1'b0, "top_out");
    step(10'd109, 10'd52, 1'b1, 12'd29,  1'b1, "right_in");
    step(10'd100, 10'd69, 1'b1, 12'd190, 1'b1, "bottom_in");
    sprite_x = 10'd200;
    step(10'd103, 10'd52, 1'b1, 12'd23, 1'b1, "no_tearing");
    filler(1);
    sprite_x = 10'd100;
  endtask

  task automatic test_mirror();
    mirror     = 1'b1;
    frame_tick = 1'b1;
    step(10'd103, 10'd52, 1'b1, 12'd23, 1'b1, "tick_same_cycle");
    frame_tick = 1'b0;
    step(10'd103, 10'd52, 1'b1, 12'd26, 1'b1, "mirror_col6");
    step(10'd100, 10'd50, 1'b1, 12'd9,  1'b1, "mirror_col9");
    step(10'd109, 10'd50, 1'b1, 12'd0,  1'b0, "mirror_transp");
    filler(1);
  endtask

  task automatic test_anim();
    mirror  = 1'b0;
    anim_en = 1'b1;
    tick_frames(7);
    check_frame(2'd0, "anim_7_ticks");
    frame_tick = 1'b1;
    step(10'd101, 10'd50, 1'b1, 12'd1, 1'b1, "anim_old_frame");
    frame_tick = 1'b0;
    check_frame(2'd1, "anim_8_ticks");
    step(10'd100, 10'd50, 1'b1, 12'd200, 1'b1, "frame1_px0");
    step(10'd101, 10'd51, 1'b1, 12'd211, 1'b1, "frame1_px11");
    filler(1);
    tick_frames(8);
    check_frame(2'd2, "anim_16_ticks");
    tick_frames(8);
    check_frame(2'd3, "anim_24_ticks");
    tick_frames(8);
    check_frame(2'd0, "anim_wrap_32");
    tick_frames(3);
    anim_en = 1'b0;
    tick_frames(20);
    check_frame(2'd0, "anim_hold");
    anim_en = 1'b1;
    tick_frames(4);
    check_frame(2'd0, "held_cnt_pre");
    tick_frames(1);
    check_frame(2'd1, "held_cnt");
    tick_frames(24);
    check_frame(2'd0, "back_to_0");
    anim_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    step(10'd100, 10'd50, 1'b1, 12'd0, 1'b0, "transparent_key");
    for (int i = 0; i < 10; i++)
      step(10'(100 + i), 10'd51, 1'b1, 12'(10 + i), 1'b1, "stream");
    filler(1);
  endtask

  task automatic test_reset_mid();
    anim_en = 1'b1;
    tick_frames(16);
    anim_en = 1'b0;
    check_frame(2'd2, "pre_reset_frame");
    step(10'd100, 10'd51, 1'b1, 12'd410, 1'b1, "pre_reset");
    step(10'd101, 10'd51, 1'b1, 12'd0,   1'b0, "flushed_by_reset");
    reset = 1'b1;
    step(10'd102, 10'd51, 1'b1, 12'd0,   1'b0, "during_reset");
    check_outputs_zero("reset_mid_outputs");
    check_frame(2'd0, "reset_mid_frame");
    reset = 1'b0;
    step(10'd3,   10'd2,  1'b1, 12'd23,  1'b1, "refill_origin");
    step(10'd103, 10'd52, 1'b1, 12'd0,   1'b0, "old_pos_gone");
    filler(1);
  endtask

  initial begin
    for (int a = 0; a < 800; a++) dut.rom[a] = 12'(a);
    reset      = 1'b1;
    pix_x      = 10'd1023;
    pix_y      = 10'd1023;
    sprite_x   = 10'd0;
    sprite_y   = 10'd0;
    mirror     = 1'b0;
    anim_en    = 1'b0;
    frame_tick = 1'b0;

    test_reset();
    test_basic();
    test_box_edges();
    test_mirror();
    test_anim();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
